fft_frame_streamer: RTL and testbench

Output-side companion to the parallel `fft` core. Captures one complete frame of N complex bins from the core's parallel `X_real`/`X_im` outputs and streams it out one bin per beat over a valid/ready interface. Downstream logic (UART/DMA bridge, magnitude detector) therefore never needs N×W parallel wires. Sits directly after `fft`, mirroring the frame loader on its input side.

---
 rtl/fft_pkg.sv | 11 +
 rtl/fft_frame_streamer_abs_sum.sv | 18 +
 rtl/fft_frame_streamer.sv | 104 ++++++++++
 tb/tb_fft_frame_streamer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and constants for the fft core and its frame loader/streamer.
package fft_pkg;

  localparam int FRAC = 8;

  typedef enum logic {
    IDLE,
    SEND
  } stream_state_t;

endpackage

// File: rtl/fft_frame_streamer_abs_sum.sv
// abs_sum: W+1-bit |a|+|b| for signed W-bit operands.
module abs_sum #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic        [W:0]   sum
);

  logic [W-1:0] abs_a;
  logic [W-1:0] abs_b;

  // the most negative value negates to 2^(W-1), still exact as unsigned
  assign abs_a = a[W-1] ? (~a + 1'b1) : a;
  assign abs_b = b[W-1] ? (~b + 1'b1) : b;
  assign sum   = {1'b0, abs_a} + {1'b0, abs_b};

endmodule

// File: rtl/fft_frame_streamer.sv
// Captures one parallel fft frame and streams it out one bin per beat.
// Optional out_mag (|re|+|im|) port enabled by FFT_STREAM_MAG_EN.
module fft_frame_streamer
  import fft_pkg::*;
#(
  parameter  int N    = 8,
  parameter  int W    = 16,
  localparam int IDXW = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_valid,
  output logic                frame_ready,
  input  logic signed [W-1:0] X_real [0:N-1],
  input  logic signed [W-1:0] X_im   [0:N-1],
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_real,
  output logic signed [W-1:0] out_im,
  output logic [IDXW-1:0]     out_index,
  output logic                out_last
`ifdef FFT_STREAM_MAG_EN
  ,
  output logic [W:0]          out_mag
`endif
);

  stream_state_t       state;
  logic [IDXW-1:0]     idx;
  logic signed [W-1:0] bank_re [N];
  logic signed [W-1:0] bank_im [N];
  logic                capture;
  logic                send;
  logic                at_last;

  assign capture = frame_valid && frame_ready;
  assign send    = (state == SEND);
  assign at_last = (idx == IDXW'(N - 1));

  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < N; i++) begin
        bank_re[i] <= X_real[i];
        bank_im[i] <= X_im[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      frame_ready <= 1'b1;
      out_valid   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (capture) begin
            state       <= SEND;
            idx         <= '0;
            frame_ready <= 1'b0;
            out_valid   <= 1'b1;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (at_last) begin
              state       <= IDLE;
              idx         <= '0;
              frame_ready <= 1'b1;
              out_valid   <= 1'b0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    out_real  = '0;
    out_im    = '0;
    out_index = '0;
    out_last  = 1'b0;
    if (send) begin
      out_real  = bank_re[idx];
      out_im    = bank_im[idx];
      out_index = idx;
      out_last  = at_last;
    end
  end

`ifdef FFT_STREAM_MAG_EN
  abs_sum #(
    .W (W)
  ) u_abs_sum (
    .a   (out_real),
    .b   (out_im),
    .sum (out_mag)
  );
`endif

endmodule

// File: tb/tb_fft_frame_streamer.sv
// Scoreboard bench for fft_frame_streamer (N=8, W=16), random data and backpressure.
module tb_fft_frame_streamer;

  localparam int N = 8;
  localparam int W = 16;

  typedef struct {
    logic [W-1:0] re;
    logic [W-1:0] im;
    int           idx;
    bit           last;
  } beat_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                frame_valid = 1'b0;
  logic                frame_ready;
  logic signed [W-1:0] x_re [0:N-1];
  logic signed [W-1:0] x_im [0:N-1];
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic signed [W-1:0] out_real;
  logic signed [W-1:0] out_im;
  logic [2:0]          out_index;
  logic                out_last;
`ifdef FFT_STREAM_MAG_EN
  logic [W:0]          out_mag;
`endif

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;
  beat_t sb [$];
  logic signed [W-1:0] fr_re [N];
  logic signed [W-1:0] fr_im [N];

  fft_frame_streamer #(
    .N (N),
    .W (W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .X_real      (x_re),
    .X_im        (x_im),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_real    (out_real),
    .out_im      (out_im),
    .out_index   (out_index),
    .out_last    (out_last)
`ifdef FFT_STREAM_MAG_EN
    ,
    .out_mag     (out_mag)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // 0 random, 1 always ready, 2 alternate 1,0
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       out_ready = 1'b1;
        2:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on every accepted beat.
  initial begin
    bit    stall_prev = 0;
    bit    last_pend = 0;
    logic [2*W+3:0] held = '0;
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 0;
        last_pend  = 0;
      end else begin
        if (last_pend) begin
          checks++;
          if (!(frame_ready && !out_valid)) begin
            errors++;
            $display("FAIL after_last: frame_ready=%0b out_valid=%0b need 1/0",
                     frame_ready, out_valid);
          end
          last_pend = 0;
        end
        if (out_valid) begin
          if (stall_prev) begin
            checks++;
            if ({out_real, out_im, out_index, out_last} != held) begin
              errors++;
              $display("FAIL stall_hold: got %h held %h",
                       {out_real, out_im, out_index, out_last}, held);
            end
          end
          if (out_ready) begin
            stall_prev = 0;
            checks++;
            if (sb.size() == 0) begin
              errors++;
              $display("FAIL extra_beat: idx %0d re %h with empty scoreboard",
                       out_index, out_real);
            end else begin
              e = sb.pop_front();
              if (out_real !== e.re || out_im !== e.im ||
                  out_index !== 3'(e.idx) || out_last !== e.last) begin
                errors++;
                $display("FAIL beat: got re %h im %h idx %0d last %0b need re %h im %h idx %0d last %0b",
                         out_real, out_im, out_index, out_last,
                         e.re, e.im, e.idx, e.last);
              end
`ifdef FFT_STREAM_MAG_EN
              begin
                int a, b;
                a = $signed(e.re);
                b = $signed(e.im);
                a = (a < 0) ? -a : a;
                b = (b < 0) ? -b : b;
                checks++;
                if (out_mag !== 17'(a + b)) begin
                  errors++;
                  $display("FAIL mag: got %0d need %0d", out_mag, a + b);
                end
              end
`endif
              if (e.last) last_pend = 1;
            end
          end else begin
            stall_prev = 1;
            held = {out_real, out_im, out_index, out_last};
          end
        end else begin
          stall_prev = 0;
          checks++;
          if (out_real !== '0 || out_im !== '0 || out_index !== '0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL idle_zero: re %h im %h idx %0d last %0b need all 0",
                     out_real, out_im, out_index, out_last);
          end
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!frame_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL ready_timeout: frame_ready=%0b need 1", frame_ready);
    end
  endtask

  task automatic send_frame();
    wait_ready();
    for (int i = 0; i < N; i++) begin
      beat_t b;
      x_re[i] = fr_re[i];
      x_im[i] = fr_im[i];
      b.re   = fr_re[i];
      b.im   = fr_im[i];
      b.idx  = i;
      b.last = (i == N - 1);
      sb.push_back(b);
    end
    frame_valid = 1'b1;
    @(posedge clk);
    #1;
    frame_valid = 1'b0;
  endtask

  task automatic rand_frame();
    for (int i = 0; i < N; i++) begin
      fr_re[i] = W'($urandom);
      fr_im[i] = W'($urandom);
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < N; i++) begin
      x_re[i] = '0;
      x_im[i] = '0;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (!(frame_ready === 1'b1 && out_valid === 1'b0 && out_index === 3'd0 &&
          out_real === '0 && out_im === '0)) begin
      errors++;
      $display("FAIL reset: ready %0b valid %0b idx %0d re %h im %h need 1 0 0 0 0",
               frame_ready, out_valid, out_index, out_real, out_im);
    end
    #2 rst_n = 1'b1;

    // ramp frame, always ready, check latency to frame_ready
    rdy_mode = 1;
    for (int i = 0; i < N; i++) begin
      fr_re[i] = W'(i * 256);
      fr_im[i] = W'(-i * 256);
    end
    send_frame();
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (frame_ready) break;
      n++;
    end
    checks++;
    if (n != N) begin
      errors++;
      $display("FAIL frame_latency: got %0d cycles need %0d", n, N);
    end

    // alternating backpressure
    rdy_mode = 2;
    rand_frame();
    send_frame();

    // magnitude corner bins
    rdy_mode = 1;
    rand_frame();
    fr_re[0] = 16'sh8000;
    fr_im[0] = 16'sh8000;
    fr_re[1] = 16'sd256;
    fr_im[1] = -16'sd512;
    send_frame();

    // input isolation during SEND
    rdy_mode = 0;
    rand_frame();
    send_frame();
    @(negedge clk);
    checks++;
    if (frame_ready !== 1'b0) begin
      errors++;
      $display("FAIL isolation_ready: frame_ready=%0b need 0", frame_ready);
    end
    for (int i = 0; i < N; i++) begin
      x_re[i] = W'($urandom);
      x_im[i] = W'($urandom);
    end
    frame_valid = 1'b1;
    @(posedge clk);
    #1;
    frame_valid = 1'b0;

    // random frames with random backpressure
    repeat (6) begin
      rand_frame();
      send_frame();
    end

    // reset at index 3
    rdy_mode = 1;
    rand_frame();
    send_frame();
    n = 0;
    @(negedge clk);
    while (!(out_valid && out_index == 3'd3) && n < 20) begin
      @(negedge clk);
      n++;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (!(out_valid === 1'b0 && frame_ready === 1'b1 && out_index === 3'd0 &&
          out_real === '0 && out_im === '0 && n < 20)) begin
      errors++;
      $display("FAIL mid_reset: valid %0b ready %0b idx %0d re %h wait %0d need 0 1 0 0",
               out_valid, frame_ready, out_index, out_real, n);
    end
    sb.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;

    rand_frame();
    send_frame();

    wait_ready();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d beats missing need 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
